multi_lane_serializer: RTL and testbench

MULTI_LANE_SERIALIZER -- requirements
Module: multi_lane_serializer

---
 rtl/multi_lane_serializer_pkg.sv | 50 +++++
 rtl/ser_word_buf.sv | 56 +++++
 rtl/multi_lane_serializer.sv | 148 ++++++++++++++
 tb/tb_multi_lane_serializer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_lane_serializer_pkg.sv
// ---------------------------------------------------------------------------
// multi_lane_serializer_pkg
// Shared types and helpers for the multi-lane serializer.
//   ser_state_e  : shift-stage FSM states (IDLE, SHIFT)
//   eff_len()    : effective bit length of a word from its mod field
//   beat_count() : number of LANES-wide beats needed for a length
//   final_keep() : keep mask for the last beat of a word (LSB-aligned,
//                  MAX_LANES wide; caller truncates to LANES)
// ---------------------------------------------------------------------------
package multi_lane_serializer_pkg;

  localparam int MAX_LANES = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // A mod of zero, or one larger than the word, means "whole word".
  function automatic int eff_len(input int mod_val, input int data_w);
    return ((mod_val == 0) || (mod_val > data_w)) ? data_w : mod_val;
  endfunction

  function automatic int beat_count(input int len, input int lanes);
    return (len + lanes - 1) / lanes;
  endfunction

  // Full beat -> all lanes kept. Partial beat -> the first len%lanes lanes
  // in emission order: top lanes when MSB first, bottom lanes otherwise.
  function automatic logic [MAX_LANES-1:0] final_keep(input int len,
                                                      input int lanes,
                                                      input bit msb_first);
    logic [MAX_LANES-1:0] mask;
    int rem;
    mask = '0;
    rem  = len % lanes;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < lanes) begin
        if (rem == 0)
          mask[i] = 1'b1;
        else if (msb_first)
          mask[i] = (i >= (lanes - rem));
        else
          mask[i] = (i < rem);
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/ser_word_buf.sv
// ---------------------------------------------------------------------------
// ser_word_buf
// One-entry word buffer (data + effective length) with valid/ready on both
// sides. wr_ready is simply !full, so it never depends on wr_val.
//   clk_i, arst_n_i          : clock, asynchronous active-low reset
//   wr_data/wr_len/wr_val    : write side, wr_ready back-pressures
//   rd_data/rd_len/rd_val    : read side, rd_ready pops the entry
// ---------------------------------------------------------------------------
module ser_word_buf #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 5
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic              wr_val,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [LEN_W-1:0]  rd_len,
  output logic              rd_val,
  input  logic              rd_ready
);

  logic              full_reg;
  logic [DATA_W-1:0] data_reg;
  logic [LEN_W-1:0]  len_reg;

  logic push;
  logic pop;

  // Push is only possible while empty and pop only while full, so the two
  // never coincide.
  assign push = wr_val && !full_reg;
  assign pop  = rd_ready && full_reg;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      full_reg <= 1'b0;
      data_reg <= '0;
      len_reg  <= '0;
    end else if (push) begin
      full_reg <= 1'b1;
      data_reg <= wr_data;
      len_reg  <= wr_len;
    end else if (pop) begin
      full_reg <= 1'b0;
    end
  end

  assign wr_ready = !full_reg;
  assign rd_val   = full_reg;
  assign rd_data  = data_reg;
  assign rd_len   = len_reg;

endmodule

// File: rtl/multi_lane_serializer.sv
// ---------------------------------------------------------------------------
// multi_lane_serializer
// Breaks DATA_W-bit words (with a valid-bit count) into LANES-bit beats,
// MSB-first or LSB-first, with a shift stage plus a one-entry hold stage
// for gapless back-to-back words.
//   clk_i, arst_n_i        : clock, asynchronous active-low reset
//   data_i, data_mod_i     : input word and valid bit count (0 = full word)
//   data_val_i/data_ready_o: input handshake (ready = hold stage empty)
//   ser_data_o, ser_keep_o : output beat and per-lane valid
//   ser_val_o/ser_ready_i  : output handshake
//   busy_o                 : word in shift stage or hold stage
//   ser_last_o             : final beat flag, only with
//                            MULTI_LANE_SERIALIZER_LAST_EN defined
// ---------------------------------------------------------------------------
module multi_lane_serializer
  import multi_lane_serializer_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int LANES     = 4,
  parameter int MSB_FIRST = 1,
  localparam int MOD_W    = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              data_ready_o,
  output logic [LANES-1:0]  ser_data_o,
  output logic [LANES-1:0]  ser_keep_o,
  output logic              ser_val_o,
  input  logic              ser_ready_i,
  output logic              busy_o
`ifdef MULTI_LANE_SERIALIZER_LAST_EN
  ,
  output logic              ser_last_o
`endif
);

  localparam int CNT_W = $clog2(DATA_W / LANES + 1);

  if ((DATA_W % LANES) != 0) begin : g_bad_lanes
    $error("multi_lane_serializer: DATA_W must be a multiple of LANES");
  end

  ser_state_e        state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]  beat_idx_reg, beat_idx_next;
  logic [CNT_W-1:0]  beats_reg, beats_next;
  logic [LANES-1:0]  keep_last_reg, keep_last_next;

  logic [MOD_W-1:0]  in_len;
  logic              hold_in_ready, hold_out_val, hold_push, hold_pop;
  logic [DATA_W-1:0] hold_out_data;
  logic [MOD_W-1:0]  hold_out_len;

  logic [DATA_W-1:0] load_data;
  logic [MOD_W-1:0]  load_len;
  logic              accept, consume, final_beat, last_consume, shift_free;
  logic [LANES-1:0]  beat_raw, keep_cur;

  assign in_len = MOD_W'(eff_len(int'(data_mod_i), DATA_W));

  assign ser_val_o    = (state_reg == SHIFT);
  assign data_ready_o = hold_in_ready;
  assign accept       = data_val_i && data_ready_o;
  assign consume      = ser_val_o && ser_ready_i;
  assign final_beat   = (beat_idx_reg == (beats_reg - 1'b1));
  assign last_consume = consume && final_beat;
  // Shift stage can take a new word this cycle.
  assign shift_free   = (state_reg == IDLE) || last_consume;

  // A pending hold word always has priority; while hold is full the input
  // is not ready, so a direct load can only happen with hold empty.
  assign hold_pop  = shift_free && hold_out_val;
  assign hold_push = accept && !shift_free;
  assign load_data = hold_out_val ? hold_out_data : data_i;
  assign load_len  = hold_out_val ? hold_out_len : in_len;

  ser_word_buf #(
    .DATA_W(DATA_W),
    .LEN_W (MOD_W)
  ) u_hold (
    .clk_i   (clk_i),
    .arst_n_i(arst_n_i),
    .wr_data (data_i),
    .wr_len  (in_len),
    .wr_val  (hold_push),
    .wr_ready(hold_in_ready),
    .rd_data (hold_out_data),
    .rd_len  (hold_out_len),
    .rd_val  (hold_out_val),
    .rd_ready(hold_pop)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      beat_idx_reg  <= '0;
      beats_reg     <= '0;
      keep_last_reg <= '0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      beat_idx_reg  <= beat_idx_next;
      beats_reg     <= beats_next;
      keep_last_reg <= keep_last_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    beat_idx_next  = beat_idx_reg;
    beats_next     = beats_reg;
    keep_last_next = keep_last_reg;
    if (shift_free && (hold_out_val || accept)) begin
      state_next     = SHIFT;
      shift_next     = load_data;
      beat_idx_next  = '0;
      beats_next     = CNT_W'(beat_count(int'(load_len), LANES));
      keep_last_next = LANES'(final_keep(int'(load_len), LANES, MSB_FIRST != 0));
    end else if (last_consume) begin
      state_next = IDLE;
    end else if (consume) begin
      // The next beat is always at the same end of the shift register.
      shift_next    = (MSB_FIRST != 0) ? (shift_reg << LANES) : (shift_reg >> LANES);
      beat_idx_next = beat_idx_reg + 1'b1;
    end
  end

  assign beat_raw = (MSB_FIRST != 0) ? shift_reg[DATA_W-1 -: LANES] : shift_reg[LANES-1:0];
  assign keep_cur = final_beat ? keep_last_reg : {LANES{1'b1}};

  // Unkept lanes carry trailing bits beyond the valid length; force them to 0.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign ser_keep_o[gi] = ser_val_o && keep_cur[gi];
    assign ser_data_o[gi] = ser_val_o && keep_cur[gi] && beat_raw[gi];
  end

  assign busy_o = ser_val_o || hold_out_val;

`ifdef MULTI_LANE_SERIALIZER_LAST_EN
  assign ser_last_o = ser_val_o && final_beat;
`endif

endmodule

// File: tb/tb_multi_lane_serializer.sv
module tb_multi_lane_serializer;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [15:0] data_i;
  logic [4:0]  data_mod;
  logic        data_val;
  logic        data_ready;
  logic [3:0]  ser_data, ser_keep;
  logic        ser_val, ser_ready, busy;
  logic        ser_last;

  logic [15:0] l_data;
  logic [4:0]  l_mod;
  logic        l_val, l_ready;
  logic [3:0]  l_ser_data, l_ser_keep;
  logic        l_ser_val, l_ser_ready, l_busy;
  logic        l_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_lane_serializer #(.DATA_W(16), .LANES(4), .MSB_FIRST(1)) u_dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .data_i      (data_i),
    .data_mod_i  (data_mod),
    .data_val_i  (data_val),
    .data_ready_o(data_ready),
    .ser_data_o  (ser_data),
    .ser_keep_o  (ser_keep),
    .ser_val_o   (ser_val),
    .ser_ready_i (ser_ready),
    .busy_o      (busy)
`ifdef MULTI_LANE_SERIALIZER_LAST_EN
    ,
    .ser_last_o  (ser_last)
`endif
  );

  multi_lane_serializer #(.DATA_W(16), .LANES(4), .MSB_FIRST(0)) u_lsb (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .data_i      (l_data),
    .data_mod_i  (l_mod),
    .data_val_i  (l_val),
    .data_ready_o(l_ready),
    .ser_data_o  (l_ser_data),
    .ser_keep_o  (l_ser_keep),
    .ser_val_o   (l_ser_val),
    .ser_ready_i (l_ser_ready),
    .busy_o      (l_busy)
`ifdef MULTI_LANE_SERIALIZER_LAST_EN
    ,
    .ser_last_o  (l_last)
`endif
  );

`ifndef MULTI_LANE_SERIALIZER_LAST_EN
  assign ser_last = 1'b0;
  assign l_last   = 1'b0;
`endif

  typedef struct {
    logic [15:0] data;
    logic [4:0]  mod;
    int          nb;
    logic [15:0] beats;   // emission order, first beat in the top nibble
    logic [15:0] keeps;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Present a word and return #1 after the edge that accepted it.
  task automatic send(input logic [15:0] d, input logic [4:0] m);
    @(negedge clk);
    data_i   = d;
    data_mod = m;
    data_val = 1'b1;
    for (int t = 0; t < 50 && !data_ready; t++) @(negedge clk);
    if (!data_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: data_ready stuck 0 expected 1");
    end
    @(posedge clk);
    #1;
    data_val = 1'b0;
  endtask

  // Starts #1 after the accepting edge: first beat must already be visible.
  task automatic expect_word(input logic [15:0] beats, input logic [15:0] keeps,
                             input int nb, input string tag);
    for (int k = 0; k < nb; k++) begin
      chk($sformatf("%s_b%0d_val", tag, k), 32'(ser_val), 32'd1);
      chk($sformatf("%s_b%0d_data", tag, k), 32'(ser_data), 32'(beats[15-4*k -: 4]));
      chk($sformatf("%s_b%0d_keep", tag, k), 32'(ser_keep), 32'(keeps[15-4*k -: 4]));
`ifdef MULTI_LANE_SERIALIZER_LAST_EN
      chk($sformatf("%s_b%0d_last", tag, k), 32'(ser_last), 32'(k == nb - 1));
`endif
      @(posedge clk);
      #1;
    end
    chk($sformatf("%s_idle", tag), 32'(ser_val), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bb_beats;
    logic [15:0] lsb_beats;
    logic [15:0] lsb_keeps;
    logic [15:0] lsb_full;

    vecs[0] = '{16'hA5C3, 5'd0,  4, 16'hA5C3, 16'hFFFF};
    vecs[1] = '{16'hA5C3, 5'd6,  2, 16'hA400, 16'hFC00};
    vecs[2] = '{16'hA5C3, 5'd17, 4, 16'hA5C3, 16'hFFFF};
    vecs[3] = '{16'hA5C3, 5'd16, 4, 16'hA5C3, 16'hFFFF};
    vecs[4] = '{16'hFFFF, 5'd1,  1, 16'h8000, 16'h8000};
    vecs[5] = '{16'h1234, 5'd8,  2, 16'h1200, 16'hFF00};
    vecs[6] = '{16'hBEEF, 5'd13, 4, 16'hBEE8, 16'hFFF8};
    vecs[7] = '{16'h5A5A, 5'd4,  1, 16'h5000, 16'hF000};
    vecs[8] = '{16'hFFFF, 5'd3,  1, 16'hE000, 16'hE000};
    vecs[9] = '{16'hFFFF, 5'd31, 4, 16'hFFFF, 16'hFFFF};

    arst_n = 1'b0; data_i = '0; data_mod = '0; data_val = 1'b0; ser_ready = 1'b1;
    l_data = '0; l_mod = '0; l_val = 1'b0; l_ser_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_val", 32'(ser_val), 32'd0);
    chk("rst_data", 32'(ser_data), 32'd0);
    chk("rst_keep", 32'(ser_keep), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(data_ready), 32'd1);
    @(negedge clk);
    arst_n = 1'b1;

    // Single-word vectors
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].data, vecs[i].mod);
      expect_word(vecs[i].beats, vecs[i].keeps, vecs[i].nb, $sformatf("vec%0d", i));
    end

    // Back-to-back words: 8 gapless beats, ready low only while hold is full
    bb_beats = 32'hA5C31234;
    @(negedge clk);
    data_i = 16'hA5C3; data_mod = 5'd0; data_val = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) data_i = 16'h1234;
      if (k == 1) data_val = 1'b0;
      chk($sformatf("b2b_c%0d_val", k), 32'(ser_val), 32'(k < 8));
      if (k < 8)
        chk($sformatf("b2b_c%0d_data", k), 32'(ser_data), 32'(bb_beats[31-4*k -: 4]));
      chk($sformatf("b2b_c%0d_ready", k), 32'(data_ready), 32'(!(k >= 1 && k <= 3)));
      chk($sformatf("b2b_c%0d_busy", k), 32'(busy), 32'(k < 8));
    end

    // Back-pressure on beat 2 for three cycles
    send(16'hA5C3, 5'd0);
    chk("bp_b0_data", 32'(ser_data), 32'hA);
    @(posedge clk);
    #1;
    chk("bp_b1_data", 32'(ser_data), 32'h5);
    ser_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_stall%0d_val", s), 32'(ser_val), 32'd1);
      chk($sformatf("bp_stall%0d_data", s), 32'(ser_data), 32'h5);
      chk($sformatf("bp_stall%0d_keep", s), 32'(ser_keep), 32'hF);
    end
    ser_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_b2_data", 32'(ser_data), 32'hC);
    @(posedge clk);
    #1;
    chk("bp_b3_data", 32'(ser_data), 32'h3);
    @(posedge clk);
    #1;
    chk("bp_idle", 32'(ser_val), 32'd0);

    // Reset mid-word with the hold stage full
    @(negedge clk);
    data_i = 16'hA5C3; data_mod = 5'd0; data_val = 1'b1;
    @(posedge clk);
    #1;
    data_i = 16'h5A5A;
    @(posedge clk);
    #1;
    data_val = 1'b0;
    chk("mr_b1_data", 32'(ser_data), 32'h5);
    chk("mr_hold_full", 32'(data_ready), 32'd0);
    #2;
    arst_n = 1'b0;
    #1;
    chk("mr_val", 32'(ser_val), 32'd0);
    chk("mr_data", 32'(ser_data), 32'd0);
    chk("mr_keep", 32'(ser_keep), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ready", 32'(data_ready), 32'd1);
    @(negedge clk);
    arst_n = 1'b1;
    data_i = 16'h1234; data_mod = 5'd0; data_val = 1'b1;
    @(posedge clk);
    #1;
    data_val = 1'b0;
    expect_word(16'h1234, 16'hFFFF, 4, "after_rst");

    // LSB-first instance
    lsb_beats = 16'h3000; lsb_keeps = 16'hF300;
    @(negedge clk);
    l_data = 16'hA5C3; l_mod = 5'd6; l_val = 1'b1;
    @(posedge clk);
    #1;
    l_val = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("lsb6_b%0d_val", k), 32'(l_ser_val), 32'd1);
      chk($sformatf("lsb6_b%0d_data", k), 32'(l_ser_data), 32'(lsb_beats[15-4*k -: 4]));
      chk($sformatf("lsb6_b%0d_keep", k), 32'(l_ser_keep), 32'(lsb_keeps[15-4*k -: 4]));
      @(posedge clk);
      #1;
    end
    chk("lsb6_idle", 32'(l_ser_val), 32'd0);

    lsb_full = 16'h3C5A;
    @(negedge clk);
    l_data = 16'hA5C3; l_mod = 5'd0; l_val = 1'b1;
    @(posedge clk);
    #1;
    l_val = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lsb0_b%0d_data", k), 32'(l_ser_data), 32'(lsb_full[15-4*k -: 4]));
      chk($sformatf("lsb0_b%0d_keep", k), 32'(l_ser_keep), 32'hF);
      @(posedge clk);
      #1;
    end
    chk("lsb0_idle", 32'(l_ser_val), 32'd0);
    chk("lsb0_busy", 32'(l_busy), 32'd0);
    chk("lsb0_last_low", 32'(l_last), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
